// File: rtl/eth_type_demux.sv
// Steers an Ethernet header + payload frame to one of M_COUNT ports by EtherType (lowest matching index wins).
// Header out 1 cycle after accept; payload via 2-entry skid, 1-cycle latency at full rate, source stalls while temp is full.
module eth_type_demux #(
  parameter int                    M_COUNT        = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter bit                    KEEP_ENABLE    = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int                    USER_WIDTH     = 1,
  parameter logic [M_COUNT*16-1:0] MATCH_TYPES    = {16'h86DD, 16'h0806, 16'h0800, 16'h88F7},
  parameter int                    DEFAULT_PORT   = 0,
  parameter bit                    DROP_UNMATCHED = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           s_eth_hdr_valid,
  output logic                           s_eth_hdr_ready,
  input  logic [47:0]                    s_eth_dest_mac,
  input  logic [47:0]                    s_eth_src_mac,
  input  logic [15:0]                    s_eth_type,
  input  logic [DATA_WIDTH-1:0]          s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_eth_payload_axis_tkeep,
  input  logic                           s_eth_payload_axis_tvalid,
  output logic                           s_eth_payload_axis_tready,
  input  logic                           s_eth_payload_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_eth_payload_axis_tuser,
  output logic [M_COUNT-1:0]             m_eth_hdr_valid,
  input  logic [M_COUNT-1:0]             m_eth_hdr_ready,
  output logic [M_COUNT*48-1:0]          m_eth_dest_mac,
  output logic [M_COUNT*48-1:0]          m_eth_src_mac,
  output logic [M_COUNT*16-1:0]          m_eth_type,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_eth_payload_axis_tkeep,
  output logic [M_COUNT-1:0]             m_eth_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_eth_payload_axis_tready,
  output logic [M_COUNT-1:0]             m_eth_payload_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_eth_payload_axis_tuser,
  input  logic                           enable,
  output logic [31:0]                    drop_count,
  output logic                           busy
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;

  logic                    hdr_rdy_q;
  logic [M_COUNT-1:0]      hdr_vld_q, hdr_vld_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [47:0]             dest_q, src_q;
  logic [15:0]             type_q;
  logic [31:0]             drop_q;

  logic                    match_vld;
  logic [SEL_W-1:0]        match_port;
  logic [M_COUNT-1:0]      sel_oh;
  logic                    hdr_acc, hdr_fwd, hdr_drop;
  logic                    pay_rdy, beat_acc, fwd_acc;

  // Skid buffer: each entry carries its own port tag so a drained beat
  // never follows a select that has already moved on to the next frame.
  logic                    out_vld_q, tmp_vld_q;
  logic [SEL_W-1:0]        out_port_q, tmp_port_q;
  logic [DATA_WIDTH-1:0]   out_dat_q, tmp_dat_q;
  logic [KEEP_WIDTH-1:0]   out_keep_q, tmp_keep_q;
  logic                    out_last_q, tmp_last_q;
  logic [USER_WIDTH-1:0]   out_user_q, tmp_user_q;
  logic                    out_rdy;
  logic [KEEP_WIDTH-1:0]   keep_out;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    match_vld  = 1'b0;
    match_port = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (s_eth_type == MATCH_TYPES[i*16 +: 16]) begin
        match_vld  = 1'b1;
        match_port = SEL_W'(i);
      end
    end
  end

  assign sel_d    = match_vld ? match_port : SEL_W'(DEFAULT_PORT);
  assign sel_oh   = M_COUNT'(1) << sel_d;
  assign hdr_acc  = s_eth_hdr_valid && hdr_rdy_q;
  assign beat_acc = s_eth_payload_axis_tvalid && pay_rdy;
  assign fwd_acc  = beat_acc && (state_q == ST_FWD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_drop) begin
          state_d = ST_DROP;
        end else if (hdr_fwd) begin
          state_d = ST_FWD;
        end
      end
      ST_FWD, ST_DROP: begin
        if (beat_acc && s_eth_payload_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pay_rdy  = 1'b0;
    hdr_fwd  = 1'b0;
    hdr_drop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hdr_fwd  = hdr_acc && (match_vld || !DROP_UNMATCHED);
        hdr_drop = hdr_acc && !match_vld && DROP_UNMATCHED;
      end
      ST_FWD:  pay_rdy = enable && !tmp_vld_q;
      ST_DROP: pay_rdy = enable;
      default: pay_rdy = 1'b0;
    endcase
  end

  assign hdr_vld_d = (hdr_vld_q & ~m_eth_hdr_ready) | (hdr_fwd ? sel_oh : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_rdy_q <= 1'b0;
      hdr_vld_q <= '0;
      sel_q     <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      type_q    <= '0;
    end else begin
      hdr_rdy_q <= (state_d == ST_IDLE) && (hdr_vld_d == '0) && enable;
      hdr_vld_q <= hdr_vld_d;
      if (hdr_acc) begin
        sel_q  <= sel_d;
        dest_q <= s_eth_dest_mac;
        src_q  <= s_eth_src_mac;
        type_q <= s_eth_type;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (hdr_drop && (drop_q != 32'hFFFF_FFFF)) begin
      drop_q <= drop_q + 32'd1;
    end
  end

  assign out_rdy = out_vld_q && m_eth_payload_axis_tready[out_port_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_port_q <= '0;
      out_dat_q  <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      out_user_q <= '0;
      tmp_vld_q  <= 1'b0;
      tmp_port_q <= '0;
      tmp_dat_q  <= '0;
      tmp_keep_q <= '0;
      tmp_last_q <= 1'b0;
      tmp_user_q <= '0;
    end else if (fwd_acc) begin
      // fwd_acc implies temp is empty, so only the output register can be busy.
      if (!out_vld_q || out_rdy) begin
        out_vld_q  <= 1'b1;
        out_port_q <= sel_q;
        out_dat_q  <= s_eth_payload_axis_tdata;
        out_keep_q <= s_eth_payload_axis_tkeep;
        out_last_q <= s_eth_payload_axis_tlast;
        out_user_q <= s_eth_payload_axis_tuser;
      end else begin
        tmp_vld_q  <= 1'b1;
        tmp_port_q <= sel_q;
        tmp_dat_q  <= s_eth_payload_axis_tdata;
        tmp_keep_q <= s_eth_payload_axis_tkeep;
        tmp_last_q <= s_eth_payload_axis_tlast;
        tmp_user_q <= s_eth_payload_axis_tuser;
      end
    end else if (out_rdy && tmp_vld_q) begin
      out_port_q <= tmp_port_q;
      out_dat_q  <= tmp_dat_q;
      out_keep_q <= tmp_keep_q;
      out_last_q <= tmp_last_q;
      out_user_q <= tmp_user_q;
      tmp_vld_q  <= 1'b0;
    end else if (out_rdy) begin
      out_vld_q <= 1'b0;
    end
  end

  assign keep_out = KEEP_ENABLE ? out_keep_q : {KEEP_WIDTH{1'b1}};

  assign s_eth_hdr_ready           = hdr_rdy_q;
  assign s_eth_payload_axis_tready = pay_rdy;
  assign m_eth_hdr_valid           = hdr_vld_q;
  assign m_eth_dest_mac            = {M_COUNT{dest_q}};
  assign m_eth_src_mac             = {M_COUNT{src_q}};
  assign m_eth_type                = {M_COUNT{type_q}};
  assign m_eth_payload_axis_tdata  = {M_COUNT{out_dat_q}};
  assign m_eth_payload_axis_tkeep  = {M_COUNT{keep_out}};
  assign m_eth_payload_axis_tlast  = {M_COUNT{out_last_q}};
  assign m_eth_payload_axis_tuser  = {M_COUNT{out_user_q}};
  assign m_eth_payload_axis_tvalid = out_vld_q ? (M_COUNT'(1) << out_port_q) : '0;
  assign drop_count                = drop_q;
  assign busy                      = (state_q != ST_IDLE) || (hdr_vld_q != '0) || out_vld_q || tmp_vld_q;

endmodule

// File: tb/tb_eth_type_demux.sv
// Bench for eth_type_demux: frame table plus hand sequences, checked against a header/beat scoreboard.
module tb_eth_type_demux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b1;

  logic         s_hdr_valid = 1'b0;
  logic         s_hdr_ready;
  logic [47:0]  s_dest = '0, s_src = '0;
  logic [15:0]  s_type = '0;
  logic [7:0]   s_tdata = '0;
  logic [0:0]   s_tkeep = 1'b1;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [0:0]   s_tuser = 1'b0;
  logic         s_tready;

  logic [3:0]   m_hdr_valid;
  logic [3:0]   m_hdr_ready = 4'hF;
  logic [191:0] m_dest, m_src;
  logic [63:0]  m_type;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep, m_tvalid, m_tlast, m_tuser;
  logic [3:0]   m_tready = 4'hF;
  logic [31:0]  drop_count;
  logic         busy;

  logic         d_hdr_valid = 1'b0, d_hdr_ready;
  logic [15:0]  d_type = '0;
  logic [7:0]   d_tdata = '0;
  logic         d_tvalid = 1'b0, d_tlast = 1'b0, d_tready;
  logic [3:0]   ones4 = 4'hF;
  logic [3:0]   d_m_hdr_valid, d_m_tkeep, d_m_tvalid, d_m_tlast, d_m_tuser;
  logic [191:0] d_m_dest, d_m_src;
  logic [63:0]  d_m_type;
  logic [31:0]  d_m_tdata, d_drop_count;
  logic         d_busy;

  eth_type_demux #(.DROP_UNMATCHED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
    .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
    .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
    .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
    .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
    .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
    .enable(enable), .drop_count(drop_count), .busy(busy)
  );

  eth_type_demux dut_def (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(d_hdr_valid), .s_eth_hdr_ready(d_hdr_ready),
    .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(d_type),
    .s_eth_payload_axis_tdata(d_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
    .s_eth_payload_axis_tvalid(d_tvalid), .s_eth_payload_axis_tready(d_tready),
    .s_eth_payload_axis_tlast(d_tlast), .s_eth_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(d_m_hdr_valid), .m_eth_hdr_ready(ones4),
    .m_eth_dest_mac(d_m_dest), .m_eth_src_mac(d_m_src), .m_eth_type(d_m_type),
    .m_eth_payload_axis_tdata(d_m_tdata), .m_eth_payload_axis_tkeep(d_m_tkeep),
    .m_eth_payload_axis_tvalid(d_m_tvalid), .m_eth_payload_axis_tready(ones4),
    .m_eth_payload_axis_tlast(d_m_tlast), .m_eth_payload_axis_tuser(d_m_tuser),
    .enable(enable), .drop_count(d_drop_count), .busy(d_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         port;
    logic [7:0] dat;
    logic       last;
    logic       user;
    int         acc;
    bit         lat;
  } beat_t;

  typedef struct {
    int          port;
    logic [15:0] etype;
    logic [47:0] dest;
  } hdr_t;

  typedef struct {
    logic [15:0] etype;
    int          nbeats;
    bit          bp;
    int          port;
    bit          drop;
    logic [31:0] drops;
  } vec_t;

  beat_t beat_q[$];
  hdr_t  hdr_q[$];
  vec_t  tbl[6];
  bit    bp_on = 1'b0;
  logic  tog = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Port 2 ready alternates 1-0-1 per cycle while backpressure is on.
  initial forever begin
    @(negedge clk);
    tog = ~tog;
    m_tready = bp_on ? {1'b1, tog, 2'b11} : 4'hF;
  end

  initial forever begin : monitor
    int p;
    beat_t e;
    hdr_t h;
    @(negedge clk);
    #2;
    if (rst_n && m_tvalid != 4'h0) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (m_tvalid[i]) p = i;
      chk("tvalid_onehot", $countones(m_tvalid), 1);
      if (m_tready[p]) begin
        chk("beat_expected", beat_q.size() != 0, 1);
        if (beat_q.size() != 0) begin
          e = beat_q.pop_front();
          chk("beat_port", p, e.port);
          chk("beat_data", m_tdata[p*8 +: 8], e.dat);
          chk("beat_last", m_tlast[p], e.last);
          chk("beat_user", m_tuser[p], e.user);
          chk("beat_keep", m_tkeep[p], 1);
          if (e.lat) chk("beat_latency", cyc, e.acc);
        end
      end
    end
    if (rst_n && m_hdr_valid != 4'h0) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (m_hdr_valid[i]) p = i;
      chk("hdr_onehot", $countones(m_hdr_valid), 1);
      chk("hdr_expected", hdr_q.size() != 0, 1);
      if (hdr_q.size() != 0) begin
        h = hdr_q.pop_front();
        chk("hdr_port", p, h.port);
        chk("hdr_type", m_type[p*16 +: 16], h.etype);
        chk("hdr_dest", m_dest[p*48 +: 48], h.dest);
      end
    end
  end

  task automatic send_hdr(input logic [15:0] t, input int port, input bit drop);
    int n;
    hdr_t h;
    n = 0;
    s_hdr_valid = 1'b1;
    s_type = t;
    s_dest = {32'hD0D0_0000, t};
    s_src  = {32'h5A5A_0000, t};
    #1;
    while (!s_hdr_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("hdr_accept", s_hdr_ready, 1);
    if (!drop) begin
      h.port = port; h.etype = t; h.dest = s_dest;
      hdr_q.push_back(h);
    end
    @(negedge clk);
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] dat, input logic last, input int port,
                           input bit push, input bit lat, output int stalls);
    beat_t e;
    stalls = 0;
    s_tvalid = 1'b1;
    s_tdata = dat;
    s_tlast = last;
    s_tuser = dat[0];
    #1;
    while (!s_tready && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk("beat_accept", s_tready, 1);
    if (push) begin
      e.port = port; e.dat = dat; e.last = last; e.user = dat[0];
      e.acc = cyc + 1; e.lat = lat;
      beat_q.push_back(e);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] t, input int nb, input int port,
                           input bit drop, input bit lat, output int stalls);
    int s;
    logic [63:0] exp_oh;
    exp_oh = drop ? 64'd0 : (64'd1 << port);
    send_hdr(t, port, drop);
    chk("hdr_vld_n1", m_hdr_valid, exp_oh);
    chk("busy_in_frame", busy, 1);
    stalls = 0;
    for (int b = 0; b < nb; b++) begin
      send_beat(8'($urandom), b == nb - 1, port, !drop, lat, s);
      stalls += s;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", busy, 0);
    chk("sb_empty", beat_q.size() + hdr_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, s;
    tbl[0] = '{16'h0800, 4, 1'b0, 1, 1'b0, 32'd0};
    tbl[1] = '{16'h1234, 4, 1'b0, 0, 1'b1, 32'd1};
    tbl[2] = '{16'h86DD, 2, 1'b0, 3, 1'b0, 32'd1};
    tbl[3] = '{16'h0806, 8, 1'b1, 2, 1'b0, 32'd1};
    tbl[4] = '{16'h88F7, 1, 1'b0, 0, 1'b0, 32'd1};
    tbl[5] = '{16'h0000, 3, 1'b0, 0, 1'b1, 32'd2};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hdr_ready", s_hdr_ready, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_m_hdr_valid", m_hdr_valid, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      bp_on = tbl[i].bp;
      run_frame(tbl[i].etype, tbl[i].nbeats, tbl[i].port, tbl[i].drop, !tbl[i].bp, st);
      if (tbl[i].bp) chk("bp_stall_seen", st > 0, 1);
      else           chk("no_stall", st, 0);
      wait_idle();
      bp_on = 1'b0;
      chk("drop_count", drop_count, tbl[i].drops);
    end

    // Unmatched type on the non-dropping instance lands on the default port.
    d_hdr_valid = 1'b1;
    d_type = 16'h1234;
    #1;
    st = 0;
    while (!d_hdr_ready && st < 200) begin @(negedge clk); #1; st++; end
    chk("def_hdr_accept", d_hdr_ready, 1);
    @(negedge clk);
    d_hdr_valid = 1'b0;
    chk("def_hdr_port0", d_m_hdr_valid, 4'b0001);
    d_tvalid = 1'b1; d_tdata = 8'h5A; d_tlast = 1'b1;
    #1 chk("def_tready", d_tready, 1);
    @(negedge clk);
    d_tvalid = 1'b0; d_tlast = 1'b0;
    chk("def_tvalid", d_m_tvalid, 4'b0001);
    chk("def_tdata", d_m_tdata[7:0], 8'h5A);
    chk("def_tlast", d_m_tlast[0], 1);
    @(negedge clk);
    chk("def_busy", d_busy, 0);
    chk("def_drop_count", d_drop_count, 0);

    // Final beat and next header offered together.
    send_hdr(16'h0800, 1, 1'b0);
    send_beat(8'h11, 1'b0, 1, 1'b1, 1'b1, s);
    send_beat(8'h22, 1'b0, 1, 1'b1, 1'b1, s);
    s_tvalid = 1'b1; s_tdata = 8'h33; s_tlast = 1'b1; s_tuser = 1'b1;
    s_hdr_valid = 1'b1; s_type = 16'h86DD; s_dest = 48'hBEEF_0000_86DD;
    #1;
    chk("same_cyc_tready", s_tready, 1);
    chk("same_cyc_hdr_blocked", s_hdr_ready, 0);
    beat_q.push_back('{1, 8'h33, 1'b1, 1'b1, cyc + 1, 1'b1});
    @(negedge clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1 chk("hdr_rdy_next_idle", s_hdr_ready, 1);
    hdr_q.push_back('{3, 16'h86DD, 48'hBEEF_0000_86DD});
    @(negedge clk);
    s_hdr_valid = 1'b0;
    chk("next_hdr_port3", m_hdr_valid, 4'b1000);
    send_beat(8'h44, 1'b1, 3, 1'b1, 1'b1, s);
    wait_idle();

    // enable low stalls the source while the output keeps draining.
    send_hdr(16'h0806, 2, 1'b0);
    send_beat(8'h55, 1'b0, 2, 1'b1, 1'b1, s);
    enable = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h66;
    #1 chk("en_off_tready", s_tready, 0);
    @(negedge clk);
    #1 chk("en_off_tready2", s_tready, 0);
    chk("en_off_drained", beat_q.size(), 0);
    @(negedge clk);
    enable = 1'b1;
    send_beat(8'h66, 1'b1, 2, 1'b1, 1'b0, s);
    wait_idle();

    // Reset in the middle of a frame.
    send_hdr(16'h0800, 1, 1'b0);
    send_beat(8'h77, 1'b0, 1, 1'b1, 1'b1, s);
    send_beat(8'h88, 1'b0, 1, 1'b1, 1'b1, s);
    s_tvalid = 1'b1; s_tdata = 8'h99;
    rst_n = 1'b0;
    beat_q.delete();
    hdr_q.delete();
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_hdr_valid", m_hdr_valid, 0);
    chk("midrst_drop_count", drop_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tready", s_tready, 0);
    s_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(16'h0806, 2, 2, 1'b0, 1'b1, st);
    wait_idle();
    chk("post_rst_drop_count", drop_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
